// File: rtl/tetris_key_pkg.sv
// Shared definitions for the Tetris key action scheduler.
//   - key index constants into the 5-bit key bank (KEY_LEFT..KEY_DROP, KEY_CNT)
//   - 3-bit command codes presented to game logic (CMD_NONE..CMD_DROP)
//   - repeat FSM state encoding
//   - key_to_cmd(): maps a key index to its command code
package tetris_key_pkg;

  localparam int KEY_LEFT   = 0;
  localparam int KEY_RIGHT  = 1;
  localparam int KEY_DOWN   = 2;
  localparam int KEY_ROTATE = 3;
  localparam int KEY_DROP   = 4;
  localparam int KEY_CNT    = 5;

  localparam logic [2:0] CMD_NONE   = 3'd0;
  localparam logic [2:0] CMD_LEFT   = 3'd1;
  localparam logic [2:0] CMD_RIGHT  = 3'd2;
  localparam logic [2:0] CMD_DOWN   = 3'd3;
  localparam logic [2:0] CMD_ROTATE = 3'd4;
  localparam logic [2:0] CMD_DROP   = 3'd5;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DAS    = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_e;

  // Command codes are laid out as key index + 1.
  function automatic logic [2:0] key_to_cmd(input logic [2:0] key_idx);
    return key_idx + 3'd1;
  endfunction

endpackage

// File: rtl/key_repeat_fsm.sv
// Auto-repeat generator for one movement key (LEFT, RIGHT or DOWN).
// Emits a one-cycle event on the press edge, then once after DAS_MS
// millisecond ticks of continuous hold, then every ARR_MS ticks.
// Ports:
//   clk       system clock
//   rst       asynchronous active-high reset
//   key_n_i   debounced key level, 0 = pressed
//   ms_tick_i one-cycle millisecond strobe
//   clr_i     forces IDLE and suppresses events (game not active)
//   event_o   one-cycle press / repeat event
module key_repeat_fsm
  import tetris_key_pkg::*;
#(
  parameter int DAS_MS = 170,
  parameter int ARR_MS = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n_i,
  input  logic ms_tick_i,
  input  logic clr_i,
  output logic event_o
);

  localparam logic [15:0] DAS_L = 16'(DAS_MS);
  localparam logic [15:0] ARR_L = 16'(ARR_MS);

  rpt_state_e  state_q, state_d;
  logic [15:0] hold_q, hold_d;
  logic        key_prev_q;
  logic        press;
  logic        das_done;
  logic        arr_done;

  // Previous level resets to "released" so a key held through reset
  // release produces a press on the first cycle afterwards.
  assign press    = key_prev_q & ~key_n_i;
  assign das_done = ms_tick_i && ((hold_q + 16'd1) == DAS_L);
  assign arr_done = ms_tick_i && ((hold_q + 16'd1) == ARR_L);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RPT_IDLE;
      hold_q     <= '0;
      key_prev_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      key_prev_q <= key_n_i;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    if (key_n_i || clr_i) begin
      state_d = RPT_IDLE;
      hold_d  = '0;
    end else begin
      case (state_q)
        RPT_IDLE: begin
          if (press) begin
            state_d = RPT_DAS;
            hold_d  = '0;
          end
        end
        RPT_DAS: begin
          if (ms_tick_i) begin
            if (das_done) begin
              state_d = RPT_REPEAT;
              hold_d  = '0;
            end else begin
              hold_d = hold_q + 16'd1;
            end
          end
        end
        RPT_REPEAT: begin
          if (ms_tick_i) begin
            hold_d = arr_done ? 16'd0 : hold_q + 16'd1;
          end
        end
        default: begin
          state_d = RPT_IDLE;
          hold_d  = '0;
        end
      endcase
    end
  end

  always_comb begin
    event_o = 1'b0;
    if (!key_n_i && !clr_i) begin
      case (state_q)
        RPT_IDLE:   event_o = press;
        RPT_DAS:    event_o = das_done;
        RPT_REPEAT: event_o = arr_done;
        default:    event_o = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/key_action_scheduler.sv
// Key action scheduler: turns five debounced active-low key levels into a
// stream of move commands with a valid/ready handshake. LEFT/RIGHT/DOWN
// auto-repeat (DAS then ARR); ROTATE/DROP fire on press only. Events set
// sticky pending bits; an arbiter picks one pending key whenever no command
// is being offered.
// Build option: define KEY_SCHED_RR_ARB_EN for round-robin arbitration
// (search starts after the last granted key). Default is fixed priority
// DROP > ROTATE > LEFT > RIGHT > DOWN.
// Ports:
//   clk            system clock
//   rst            asynchronous active-high reset
//   keys_stable_i  [4:0] key levels, 0 = pressed ([0]L [1]R [2]D [3]ROT [4]DROP)
//   game_active_i  1 = accept key events
//   cmd_valid_o    command offered
//   cmd_code_o     [2:0] command code (0 NONE .. 5 DROP)
//   cmd_ready_i    game logic accepts the offered command
module key_action_scheduler
  import tetris_key_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int DAS_MS   = 170,
  parameter int ARR_MS   = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] keys_stable_i,
  input  logic       game_active_i,
  output logic       cmd_valid_o,
  output logic [2:0] cmd_code_o,
  input  logic       cmd_ready_i
);

  localparam int TICK_DIV = CLK_FREQ / 1000;
  localparam int PRESC_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

  logic [PRESC_W-1:0]        presc_q, presc_d;
  logic                      ms_tick;
  logic [KEY_DROP:KEY_ROTATE] key_prev_q;
  logic [KEY_DROP:KEY_ROTATE] press_hi;
  logic [KEY_DOWN:KEY_LEFT]  rpt_event;
  logic [KEY_CNT-1:0]        events;
  logic [KEY_CNT-1:0]        pending_q, pending_d;
  logic                      cmd_valid_q, cmd_valid_d;
  logic [2:0]                cmd_code_q, cmd_code_d;
  logic                      accept;
  logic                      load;
  logic [2:0]                cur_idx;
  logic [2:0]                win_idx;

  // Millisecond prescaler.
  always_comb begin
    ms_tick = (presc_q == PRESC_LAST);
    presc_d = ms_tick ? '0 : presc_q + 1'b1;
  end

  // Press detect for the non-repeating keys; movement keys detect their own
  // press inside the repeat FSM.
  assign press_hi = key_prev_q & ~keys_stable_i[KEY_DROP:KEY_ROTATE];

  generate
    for (genvar gi = KEY_LEFT; gi <= KEY_DOWN; gi++) begin : g_rpt
      key_repeat_fsm #(
        .DAS_MS (DAS_MS),
        .ARR_MS (ARR_MS)
      ) u_rpt (
        .clk       (clk),
        .rst       (rst),
        .key_n_i   (keys_stable_i[gi]),
        .ms_tick_i (ms_tick),
        .clr_i     (~game_active_i),
        .event_o   (rpt_event[gi])
      );
    end
  endgenerate

  assign events  = {press_hi, rpt_event} & {KEY_CNT{game_active_i}};
  assign accept  = cmd_valid_q & cmd_ready_i;
  assign cur_idx = cmd_code_q - 3'd1;

  // Pending set: accept clears the offered key first so a same-cycle event
  // re-sets it. Pausing the game wipes everything.
  always_comb begin
    pending_d = pending_q;
    for (int i = 0; i < KEY_CNT; i++) begin
      if (accept && (cur_idx == 3'(i))) pending_d[i] = 1'b0;
    end
    pending_d = pending_d | events;
    if (!game_active_i) pending_d = '0;
  end

`ifdef KEY_SCHED_RR_ARB_EN
  logic [2:0] rr_ptr_q, rr_ptr_d;
  logic [2:0] cand;
  logic       found;

  always_comb begin
    win_idx = 3'd0;
    found   = 1'b0;
    cand    = rr_ptr_q;
    for (int j = 0; j < KEY_CNT; j++) begin
      cand = (cand == 3'(KEY_CNT - 1)) ? 3'd0 : cand + 3'd1;
      if (!found && pending_q[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
    rr_ptr_d = load ? win_idx : rr_ptr_q;
  end

  // Pointer starts on the last index so index 0 is searched first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_ptr_q <= 3'(KEY_CNT - 1);
    else     rr_ptr_q <= rr_ptr_d;
  end
`else
  always_comb begin
    if      (pending_q[KEY_DROP])   win_idx = 3'(KEY_DROP);
    else if (pending_q[KEY_ROTATE]) win_idx = 3'(KEY_ROTATE);
    else if (pending_q[KEY_LEFT])   win_idx = 3'(KEY_LEFT);
    else if (pending_q[KEY_RIGHT])  win_idx = 3'(KEY_RIGHT);
    else                            win_idx = 3'(KEY_DOWN);
  end
`endif

  // Output register: after an accept valid drops for one cycle, during which
  // the updated pending set is arbitrated.
  always_comb begin
    cmd_valid_d = cmd_valid_q;
    cmd_code_d  = cmd_code_q;
    load        = 1'b0;
    if (accept) begin
      cmd_valid_d = 1'b0;
      cmd_code_d  = CMD_NONE;
    end else if (!cmd_valid_q && game_active_i && (pending_q != '0)) begin
      cmd_valid_d = 1'b1;
      cmd_code_d  = key_to_cmd(win_idx);
      load        = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q     <= '0;
      key_prev_q  <= '1;
      pending_q   <= '0;
      cmd_valid_q <= 1'b0;
      cmd_code_q  <= CMD_NONE;
    end else begin
      presc_q     <= presc_d;
      key_prev_q  <= keys_stable_i[KEY_DROP:KEY_ROTATE];
      pending_q   <= pending_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_code_q  <= cmd_code_d;
    end
  end

  assign cmd_valid_o = cmd_valid_q;
  assign cmd_code_o  = cmd_code_q;

endmodule

// File: tb/tb_key_action_scheduler.sv
// Testbench for key_action_scheduler: directed scenarios followed by random
// key activity. A reference model derives, from tick counts since each press
// and a pending-key set, which command is offered from which cycle; accepted
// commands go to a scoreboard queue that an independent monitor drains.
module tb_key_action_scheduler;

  localparam int DAS = 3;
  localparam int ARR = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] keys = 5'h1f;
  logic       ga = 1'b1;
  logic       ready = 1'b1;
  logic       cmd_valid;
  logic [2:0] cmd_code;

  int checks = 0;
  int errors = 0;
  int cyc;

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  key_action_scheduler #(
    .CLK_FREQ (4000),
    .DAS_MS   (DAS),
    .ARR_MS   (ARR)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .keys_stable_i (keys),
    .game_active_i (ga),
    .cmd_valid_o   (cmd_valid),
    .cmd_code_o    (cmd_code),
    .cmd_ready_i   (ready)
  );

  typedef struct {
    int code;
    int start;
  } exp_t;
  exp_t sbq[$];

  // Reference model state.
  bit [4:0] m_prev;
  bit [4:0] m_pend;
  bit       m_held [3];
  int       m_ticks [3];
  bit       m_valid;
  int       m_code;
  int       m_start;
  int       m_last;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int pick(bit [4:0] p, int last);
`ifdef KEY_SCHED_RR_ARB_EN
    for (int j = 1; j <= 5; j++) begin
      int k;
      k = (last + j) % 5;
      if (((p >> k) & 5'd1) != 5'd0) return k;
    end
`else
    if (p[4]) return 4;
    if (p[3]) return 3;
    if (p[0]) return 0;
    if (p[1]) return 1;
    if (p[2]) return 2;
`endif
    return last;
  endfunction

  task automatic model_reset();
    m_prev  = 5'h1f;
    m_pend  = '0;
    m_valid = 1'b0;
    m_code  = 0;
    m_start = 0;
    m_last  = 4;
    for (int i = 0; i < 3; i++) begin
      m_held[i]  = 1'b0;
      m_ticks[i] = 0;
    end
  endtask

  // Advance the model across the coming clock edge using the inputs now set.
  task automatic model_edge();
    int       n;
    bit       tick;
    bit       acc;
    bit [4:0] evt;
    bit [4:0] old;
    bit [4:0] nxt;
    exp_t     e;
    n    = cyc + 1;
    tick = (n % 4 == 0);
    evt  = '0;
    for (int i = 0; i < 3; i++) begin
      if (keys[i] || !ga) begin
        m_held[i] = 1'b0;
      end else if (m_prev[i]) begin
        m_held[i]  = 1'b1;
        m_ticks[i] = 0;
        evt[i]     = 1'b1;
      end else if (m_held[i] && tick) begin
        m_ticks[i]++;
        if (m_ticks[i] == DAS || (m_ticks[i] > DAS && (m_ticks[i] - DAS) % ARR == 0))
          evt[i] = 1'b1;
      end
    end
    for (int i = 3; i < 5; i++) begin
      if (ga && m_prev[i] && !keys[i]) evt[i] = 1'b1;
    end
    acc = m_valid && ready;
    old = m_pend;
    if (!ga) begin
      nxt = '0;
    end else begin
      nxt = old;
      if (acc) nxt = nxt & ~(5'b00001 << (m_code - 1));
      nxt = nxt | evt;
    end
    if (acc) begin
      e.code  = m_code;
      e.start = m_start;
      sbq.push_back(e);
      m_valid = 1'b0;
    end else if (!m_valid && ga && old != '0) begin
      m_last  = pick(old, m_last);
      m_valid = 1'b1;
      m_code  = m_last + 1;
      m_start = n;
    end
    m_pend = nxt;
    m_prev = keys;
  endtask

  task automatic step(bit [4:0] k, bit r, bit g);
    @(posedge clk);
    #2;
    keys  = k;
    ready = r;
    ga    = g;
    model_edge();
  endtask

  task automatic steps(int cnt, bit [4:0] k, bit r, bit g);
    for (int i = 0; i < cnt; i++) step(k, r, g);
  endtask

  // Assert reset mid-cycle, confirm the output drops at once, release with
  // keys k held.
  task automatic do_reset(bit [4:0] k);
    @(posedge clk);
    #2;
    check("pre_reset_valid", cmd_valid, m_valid);
    keys = k;
    rst  = 1'b1;
    #1;
    check("reset_valid", cmd_valid, 0);
    check("reset_code", cmd_code, 0);
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    rst   = 1'b0;
    ready = 1'b1;
    ga    = 1'b1;
    model_edge();
  endtask

  // Monitor: protocol hold check plus scoreboard pop on every accept.
  bit         mv_prev = 1'b0;
  bit         mr_prev = 1'b0;
  logic [2:0] mc_prev = 3'd0;
  int         dut_start = 0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        mv_prev = 1'b0;
      end else begin
        if (mv_prev && !mr_prev) begin
          check("hold_valid", cmd_valid, 1);
          check("hold_code", cmd_code, mc_prev);
        end
        if (cmd_valid && !mv_prev) dut_start = cyc;
        if (cmd_valid && ready) begin
          if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_cmd actual=code %0d at cycle %0d required=no command", cmd_code, cyc);
          end else begin
            e = sbq.pop_front();
            check("cmd_code", cmd_code, e.code);
            check("cmd_start", dut_start, e.start);
            $display("cmd code=%0d offered at cycle %0d (expected code=%0d at %0d)",
                     cmd_code, dut_start, e.code, e.start);
          end
        end
        mv_prev = cmd_valid;
        mr_prev = ready;
        mc_prev = cmd_code;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [4:0] rk;
    bit       rga;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    check("reset_state_valid", cmd_valid, 0);
    check("reset_state_code", cmd_code, 0);
    rst = 1'b0;
    model_edge();
    steps(8, 5'h1f, 1, 1);

    // Tap ROTATE.
    steps(2, 5'b10111, 1, 1);
    steps(12, 5'h1f, 1, 1);

    // Hold LEFT.
    steps(40, 5'b11110, 1, 1);
    steps(12, 5'h1f, 1, 1);

    // DROP, ROTATE and RIGHT together.
    steps(3, 5'b00101, 1, 1);
    steps(12, 5'h1f, 1, 1);

    // DOWN held while the consumer stalls, then resumes.
    steps(20, 5'b11011, 0, 1);
    steps(30, 5'b11011, 1, 1);
    steps(8, 5'h1f, 1, 1);

    // Pause while LEFT is held with a command offered and pending.
    steps(14, 5'b11110, 0, 1);
    steps(4, 5'b11110, 0, 0);
    steps(10, 5'b11110, 1, 0);
    steps(20, 5'b11110, 1, 1);
    steps(2, 5'h1f, 1, 1);
    steps(3, 5'b11110, 1, 1);
    steps(8, 5'h1f, 1, 1);

    // Reset during a stalled handshake with LEFT held across release.
    steps(2, 5'b10111, 0, 1);
    steps(3, 5'h1f, 0, 1);
    do_reset(5'b11110);
    steps(6, 5'b11110, 1, 1);
    steps(8, 5'h1f, 1, 1);

    // Random key activity.
    rk  = 5'h1f;
    rga = 1'b1;
    repeat (700) begin
      for (int i = 0; i < 5; i++) begin
        if ($urandom_range(0, 19) == 0) rk[i] = ~rk[i];
      end
      if ($urandom_range(0, 79) == 0) rga = ~rga;
      step(rk, ($urandom_range(0, 3) != 0), rga);
    end

    steps(20, 5'h1f, 1, 1);
    @(negedge clk);
    #1;
    check("drain_queue", sbq.size(), 0);
    check("drain_valid", cmd_valid, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
